// File: rtl/sram_arbiter_if.sv
// Bus bundle between the Z80/loader side and the sram_arbiter, plus the RAM port.
// master = environment (CPU, loader, RAM), slave = the arbiter.
interface sram_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] cpu_address;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_rd_n;
  logic                  cpu_wr_n;
  logic                  cpu_mreq_n;
  logic                  cpu_sel;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_oe;
  logic                  cpu_wait_n;
  logic                  ld_valid;
  logic                  ld_ready;
  logic [ADDR_WIDTH-1:0] ld_address;
  logic [DATA_WIDTH-1:0] ld_wdata;
  logic                  ld_last;
  logic                  boot_done;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0] ram_datain;
  logic                  ram_cs;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_dataout;

  modport master (
    output cpu_address, cpu_wdata, cpu_rd_n, cpu_wr_n, cpu_mreq_n, cpu_sel,
    output ld_valid, ld_address, ld_wdata, ld_last, ram_dataout,
    input  cpu_rdata, cpu_oe, cpu_wait_n, ld_ready, boot_done,
    input  ram_address, ram_datain, ram_cs, ram_we
  );

  modport slave (
    input  cpu_address, cpu_wdata, cpu_rd_n, cpu_wr_n, cpu_mreq_n, cpu_sel,
    input  ld_valid, ld_address, ld_wdata, ld_last, ram_dataout,
    output cpu_rdata, cpu_oe, cpu_wait_n, ld_ready, boot_done,
    output ram_address, ram_datain, ram_cs, ram_we
  );
endinterface

// File: rtl/sram_arbiter.sv
// Shares the single-port image RAM between the asynchronous Z80 bus and the SPI
// image loader; holds the CPU in WAIT until the boot image has been written.
module sram_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter bit BOOT_ENABLE = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  sram_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    ST_BOOT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_LD_WR   = 3'd2,
    ST_CPU_RD  = 3'd3,
    ST_CPU_CAP = 3'd4,
    ST_CPU_WR  = 3'd5,
    ST_HOLD    = 3'd6
  } state_t;

  localparam state_t RESET_STATE = BOOT_ENABLE ? ST_BOOT : ST_IDLE;

  logic [SYNC_STAGES-1:0] rd_sync_r, wr_sync_r, mreq_sync_r;
  state_t                 state_r, state_next_s;
  logic                   boot_done_r, boot_done_next_s;
  logic                   wait_n_r, wait_n_next_s;
  logic                   cpu_oe_r, cpu_oe_next_s;
  logic                   ram_cs_r, ram_we_r, ld_last_r;
  logic [ADDR_WIDTH-1:0]  ram_address_r;
  logic [DATA_WIDTH-1:0]  ram_datain_r, cpu_rdata_r;
  logic                   rd_s, wr_s, mreq_s, rd_next_s, mreq_next_s;
  logic                   cpu_req_s, sel_read_next_s, ld_ready_s, ld_xfer_s;

  // Strobe synchronisers; idle level is 1 so reset looks like no bus cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sync_r   <= {SYNC_STAGES{1'b1}};
      wr_sync_r   <= {SYNC_STAGES{1'b1}};
      mreq_sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      rd_sync_r   <= {rd_sync_r[SYNC_STAGES-2:0], bus.cpu_rd_n};
      wr_sync_r   <= {wr_sync_r[SYNC_STAGES-2:0], bus.cpu_wr_n};
      mreq_sync_r <= {mreq_sync_r[SYNC_STAGES-2:0], bus.cpu_mreq_n};
    end
  end

  assign rd_s        = rd_sync_r[SYNC_STAGES-1];
  assign wr_s        = wr_sync_r[SYNC_STAGES-1];
  assign mreq_s      = mreq_sync_r[SYNC_STAGES-1];
  assign rd_next_s   = rd_sync_r[SYNC_STAGES-2];
  assign mreq_next_s = mreq_sync_r[SYNC_STAGES-2];
  assign cpu_req_s   = ~mreq_s & (~rd_s | ~wr_s);
  // Lets the registered WAIT drop on the very cycle the read is detected.
  assign sel_read_next_s = ~mreq_next_s & ~rd_next_s & bus.cpu_sel;

  assign ld_ready_s   = (state_r == ST_BOOT) | ((state_r == ST_IDLE) & ~cpu_req_s);
  assign ld_xfer_s    = bus.ld_valid & ld_ready_s;
  assign bus.ld_ready = ld_ready_s;

  // Next-state and next-output decode.
  always_comb begin
    state_next_s     = state_r;
    boot_done_next_s = boot_done_r;
    wait_n_next_s    = 1'b1;
    cpu_oe_next_s    = 1'b0;
    case (state_r)
      ST_BOOT: begin
        if (ld_xfer_s) state_next_s = ST_LD_WR;
        else           state_next_s = ST_BOOT;
      end
      ST_IDLE: begin
        if (cpu_req_s) begin
          if (!bus.cpu_sel) state_next_s = ST_HOLD;
          else if (!rd_s)   state_next_s = ST_CPU_RD;
          else              state_next_s = ST_CPU_WR;
        end else if (ld_xfer_s) begin
          state_next_s = ST_LD_WR;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LD_WR: begin
        if (ld_last_r && !boot_done_r) begin
          state_next_s     = ST_IDLE;
          boot_done_next_s = 1'b1;
        end else if (boot_done_r) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_BOOT;
        end
      end
      ST_CPU_RD:  state_next_s = ST_CPU_CAP;
      ST_CPU_CAP: state_next_s = ST_HOLD;
      ST_CPU_WR:  state_next_s = ST_HOLD;
      ST_HOLD: begin
        if (rd_s && wr_s && mreq_s) state_next_s = ST_IDLE;
        else                        state_next_s = ST_HOLD;
      end
      default: state_next_s = RESET_STATE;
    endcase

    if (!boot_done_next_s)
      wait_n_next_s = 1'b0;
    else if ((state_next_s == ST_CPU_RD) || (state_next_s == ST_CPU_CAP))
      wait_n_next_s = 1'b0;
    else if ((state_next_s == ST_IDLE) && sel_read_next_s)
      wait_n_next_s = 1'b0;
    else
      wait_n_next_s = 1'b1;

    if ((state_next_s == ST_HOLD) && !rd_next_s &&
        ((state_r == ST_CPU_CAP) || ((state_r == ST_HOLD) && cpu_oe_r)))
      cpu_oe_next_s = 1'b1;
    else
      cpu_oe_next_s = 1'b0;
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= RESET_STATE;
      boot_done_r   <= ~BOOT_ENABLE;
      wait_n_r      <= ~BOOT_ENABLE;
      cpu_oe_r      <= 1'b0;
      ram_cs_r      <= 1'b0;
      ram_we_r      <= 1'b0;
      ld_last_r     <= 1'b0;
      ram_address_r <= {ADDR_WIDTH{1'b0}};
      ram_datain_r  <= {DATA_WIDTH{1'b0}};
      cpu_rdata_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r     <= state_next_s;
      boot_done_r <= boot_done_next_s;
      wait_n_r    <= wait_n_next_s;
      cpu_oe_r    <= cpu_oe_next_s;
      ram_cs_r    <= (state_next_s == ST_LD_WR) || (state_next_s == ST_CPU_RD) ||
                     (state_next_s == ST_CPU_WR);
      ram_we_r    <= (state_next_s == ST_LD_WR) || (state_next_s == ST_CPU_WR);
      if (state_next_s == ST_LD_WR) begin
        ram_address_r <= bus.ld_address;
        ram_datain_r  <= bus.ld_wdata;
        ld_last_r     <= bus.ld_last;
      end else if (state_next_s == ST_CPU_WR) begin
        ram_address_r <= bus.cpu_address;
        ram_datain_r  <= bus.cpu_wdata;
      end else if (state_next_s == ST_CPU_RD) begin
        ram_address_r <= bus.cpu_address;
      end
      if (state_r == ST_CPU_CAP) cpu_rdata_r <= bus.ram_dataout;
    end
  end

  assign bus.ram_cs      = ram_cs_r;
  assign bus.ram_we      = ram_we_r;
  assign bus.ram_address = ram_address_r;
  assign bus.ram_datain  = ram_datain_r;
  assign bus.cpu_rdata   = cpu_rdata_r;
  assign bus.cpu_oe      = cpu_oe_r;
  assign bus.cpu_wait_n  = wait_n_r;
  assign bus.boot_done   = boot_done_r;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: stimulus pushes expected RAM accesses and
// read data; a negedge monitor pops and compares whatever the DUT presents.
module tb_sram_arbiter;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

  sram_arbiter #(
    .ADDR_WIDTH(16), .DATA_WIDTH(8), .SYNC_STAGES(2), .BOOT_ENABLE(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } ram_exp_t;

  ram_exp_t   ram_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] mem [0:65535];
  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int boot_wait_bad = 0;
  bit in_boot = 1'b0;
  logic oe_prev = 1'b0;

  // Synchronous RAM: read data appears the cycle after a read select.
  always @(posedge clk) begin
    if (bus.ram_cs === 1'b1) begin
      if (bus.ram_we === 1'b1) mem[bus.ram_address] <= bus.ram_datain;
      else bus.ram_dataout <= mem[bus.ram_address];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_ram(input logic we, input logic [15:0] a, input logic [7:0] d);
    ram_exp_t e;
    e.we = we; e.addr = a; e.data = d;
    ram_q.push_back(e);
  endtask

  // Monitor: every RAM select and every rising cpu_oe is matched to the queues.
  always @(negedge clk) begin : monitor
    ram_exp_t e;
    logic [7:0] r;
    if (in_boot && bus.cpu_wait_n !== 1'b0) boot_wait_bad++;
    if (bus.ram_cs === 1'b1) begin
      pulses++;
      if (ram_q.size() == 0) begin
        check("ram_unexpected_access", {15'd0, bus.ram_we, bus.ram_address}, 32'h0);
      end else begin
        e = ram_q.pop_front();
        check("ram_we", {31'd0, bus.ram_we}, {31'd0, e.we});
        check("ram_address", {16'd0, bus.ram_address}, {16'd0, e.addr});
        if (e.we) check("ram_datain", {24'd0, bus.ram_datain}, {24'd0, e.data});
      end
    end
    if (bus.cpu_oe === 1'b1 && oe_prev !== 1'b1) begin
      if (rd_q.size() == 0) begin
        check("cpu_oe_unexpected", {24'd0, bus.cpu_rdata}, 32'hFFFF_FFFF);
      end else begin
        r = rd_q.pop_front();
        check("cpu_rdata", {24'd0, bus.cpu_rdata}, {24'd0, r});
      end
    end
    oe_prev = bus.cpu_oe;
  end

  task automatic ld_write(input logic [15:0] a, input logic [7:0] d, input logic last, input bit drop);
    int n;
    @(negedge clk);
    bus.ld_valid = 1'b1; bus.ld_address = a; bus.ld_wdata = d; bus.ld_last = last;
    n = 0;
    while (bus.ld_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ld_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    if (drop) begin
      @(negedge clk);
      bus.ld_valid = 1'b0;
    end
  endtask

  task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input bit is_read,
                           input logic sel, output int wait_low, output int oe_high);
    @(negedge clk);
    bus.cpu_address = a; bus.cpu_wdata = d; bus.cpu_sel = sel; bus.cpu_mreq_n = 1'b0;
    if (is_read) bus.cpu_rd_n = 1'b0;
    else         bus.cpu_wr_n = 1'b0;
    wait_low = 0; oe_high = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.cpu_wait_n === 1'b0) wait_low++;
      if (bus.cpu_oe === 1'b1) oe_high++;
    end
    bus.cpu_rd_n = 1'b1; bus.cpu_wr_n = 1'b1; bus.cpu_mreq_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ram_cs"}, {31'd0, bus.ram_cs}, 32'd0);
    check({tag, "_ram_we"}, {31'd0, bus.ram_we}, 32'd0);
    check({tag, "_ram_address"}, {16'd0, bus.ram_address}, 32'd0);
    check({tag, "_ram_datain"}, {24'd0, bus.ram_datain}, 32'd0);
    check({tag, "_cpu_rdata"}, {24'd0, bus.cpu_rdata}, 32'd0);
    check({tag, "_cpu_oe"}, {31'd0, bus.cpu_oe}, 32'd0);
    check({tag, "_boot_done"}, {31'd0, bus.boot_done}, 32'd0);
    check({tag, "_cpu_wait_n"}, {31'd0, bus.cpu_wait_n}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wl, oh, p0, n;
    bus.cpu_address = 16'h0; bus.cpu_wdata = 8'h0; bus.cpu_sel = 1'b0;
    bus.cpu_rd_n = 1'b1; bus.cpu_wr_n = 1'b1; bus.cpu_mreq_n = 1'b1;
    bus.ld_valid = 1'b0; bus.ld_address = 16'h0; bus.ld_wdata = 8'h0; bus.ld_last = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    check("reset_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
    rst_n = 1'b1;
    in_boot = 1'b1;

    // Boot image: 256 bytes, data == low address byte
    for (int i = 0; i < 256; i++) begin
      exp_ram(1'b1, i[15:0], i[7:0]);
      ld_write(i[15:0], i[7:0], (i == 255), (i == 255));
    end
    in_boot = 1'b0;
    check("boot_done_during_last_pulse", {31'd0, bus.boot_done}, 32'd0);
    check("wait_during_last_pulse", {31'd0, bus.cpu_wait_n}, 32'd0);
    @(negedge clk);
    check("boot_done_after_last", {31'd0, bus.boot_done}, 32'd1);
    check("wait_n_after_last", {31'd0, bus.cpu_wait_n}, 32'd1);
    check("boot_pulse_count", pulses, 32'd256);
    check("boot_wait_held_low", boot_wait_bad, 32'd0);

    // Selected read of a boot byte
    exp_ram(1'b0, 16'h0042, 8'h00);
    rd_q.push_back(8'h42);
    cpu_cycle(16'h0042, 8'h00, 1'b1, 1'b1, wl, oh);
    check("read_wait_cycles", wl, 32'd3);
    check("read_oe_seen", {31'd0, oh > 0}, 32'd1);
    check("read_oe_released", {31'd0, bus.cpu_oe}, 32'd0);
    check("read_back_idle", {31'd0, bus.ld_ready}, 32'd1);

    // Write, then read it back
    exp_ram(1'b1, 16'h1234, 8'hA5);
    cpu_cycle(16'h1234, 8'hA5, 1'b0, 1'b1, wl, oh);
    check("write_wait_cycles", wl, 32'd0);
    check("write_oe_cycles", oh, 32'd0);
    exp_ram(1'b0, 16'h1234, 8'h00);
    rd_q.push_back(8'hA5);
    cpu_cycle(16'h1234, 8'h00, 1'b1, 1'b1, wl, oh);
    check("readback_wait_cycles", wl, 32'd3);

    // Unselected read: no RAM, no OE, no wait
    p0 = pulses;
    cpu_cycle(16'h0042, 8'h00, 1'b1, 1'b0, wl, oh);
    check("unsel_wait_cycles", wl, 32'd0);
    check("unsel_oe_cycles", oh, 32'd0);
    check("unsel_ram_pulses", pulses - p0, 32'd0);

    // Contention: loader raised on the read's detect cycle; CPU goes first
    p0 = pulses;
    exp_ram(1'b0, 16'h0010, 8'h00);
    rd_q.push_back(8'h10);
    exp_ram(1'b1, 16'h2000, 8'h5A);
    fork
      cpu_cycle(16'h0010, 8'h00, 1'b1, 1'b1, wl, oh);
      begin
        repeat (2) @(negedge clk);
        ld_write(16'h2000, 8'h5A, 1'b0, 1'b1);
      end
    join
    check("contention_pulses", pulses - p0, 32'd2);
    check("contention_read_wait", wl, 32'd3);
    exp_ram(1'b0, 16'h2000, 8'h00);
    rd_q.push_back(8'h5A);
    cpu_cycle(16'h2000, 8'h00, 1'b1, 1'b1, wl, oh);

    // Reissued ld_last after boot changes nothing
    exp_ram(1'b1, 16'h3000, 8'h77);
    ld_write(16'h3000, 8'h77, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    check("reissue_boot_done", {31'd0, bus.boot_done}, 32'd1);
    check("reissue_wait_n", {31'd0, bus.cpu_wait_n}, 32'd1);
    check("reissue_idle", {31'd0, bus.ld_ready}, 32'd1);

    // Reset pulsed while the read select is on the RAM
    exp_ram(1'b0, 16'h0042, 8'h00);
    @(negedge clk);
    bus.cpu_address = 16'h0042; bus.cpu_sel = 1'b1; bus.cpu_mreq_n = 1'b0; bus.cpu_rd_n = 1'b0;
    n = 0;
    while (bus.ram_cs !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("midop_reached_cpu_rd", {31'd0, n < 20}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset("midop");
    bus.cpu_rd_n = 1'b1; bus.cpu_mreq_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    p0 = pulses;
    repeat (10) @(negedge clk);
    check("midop_no_ram_cs", pulses - p0, 32'd0);
    check("midop_boot_ready", {31'd0, bus.ld_ready}, 32'd1);
    check("midop_wait_low", {31'd0, bus.cpu_wait_n}, 32'd0);
    exp_ram(1'b1, 16'h0050, 8'h99);
    ld_write(16'h0050, 8'h99, 1'b1, 1'b1);
    @(negedge clk);
    check("reboot_done", {31'd0, bus.boot_done}, 32'd1);

    repeat (4) @(negedge clk);
    check("ram_queue_drained", ram_q.size(), 32'd0);
    check("rdata_queue_drained", rd_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
